// File: rtl/booth_mul_seq.sv
// rtl/booth_mul_seq.sv - sequential radix-4 Booth signed multiplier
// Retires two multiplier bits per CALC cycle; p is registered and only moves on entry to DONE.
module booth_mul_seq #(
  parameter int WIDTH = 16
) (
  input  logic                 clk,
  input  logic                 rst_n,
  input  logic                 start,
  input  logic [WIDTH-1:0]     x,
  input  logic [WIDTH-1:0]     y,
  output logic                 busy,
  output logic                 done,
  output logic [2*WIDTH-1:0]   p
);

  localparam int PW = 2 * WIDTH;
  localparam int CW = (WIDTH / 2 > 1) ? $clog2(WIDTH / 2) : 1;
  localparam logic [CW-1:0] LAST = CW'(WIDTH / 2 - 1);

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    CALC = 2'd1,
    DONE = 2'd2
  } state_t;

  state_t          state_q, state_d;
  logic [WIDTH:0]  mreg_q, mreg_d;
  logic [WIDTH-1:0] yreg_q, yreg_d;
  logic [PW-1:0]   acc_q, acc_d;
  logic [PW-1:0]   p_q, p_d;
  logic [CW-1:0]   cnt_q, cnt_d;

  logic            pp_zero, pp_two, pp_neg;
  logic [PW-1:0]   y_ext, pp_mag, pp_ones, pp_shift, s_shift;
  logic [PW-1:0]   acc_sum;

  always_comb begin
    pp_zero = 1'b0;
    pp_two  = 1'b0;
    pp_neg  = 1'b0;
    case (mreg_q[2:0])
      3'b001, 3'b010: ;
      3'b011:         pp_two = 1'b1;
      3'b100: begin
        pp_two = 1'b1;
        pp_neg = 1'b1;
      end
      3'b101, 3'b110: pp_neg = 1'b1;
      default:        pp_zero = 1'b1;
    endcase
  end

  // Negative digits add ~mag with a carry-in at the same weight, i.e. -mag.
  always_comb begin
    y_ext    = {{WIDTH{yreg_q[WIDTH-1]}}, yreg_q};
    pp_mag   = pp_zero ? '0 : (pp_two ? (y_ext << 1) : y_ext);
    pp_ones  = pp_neg ? ~pp_mag : pp_mag;
    pp_shift = pp_ones << {cnt_q, 1'b0};
    s_shift  = {{(PW-1){1'b0}}, pp_neg} << {cnt_q, 1'b0};
    acc_sum  = acc_q + pp_shift + s_shift;
  end

  always_comb begin
    state_d = state_q;
    mreg_d  = mreg_q;
    yreg_d  = yreg_q;
    acc_d   = acc_q;
    cnt_d   = cnt_q;
    p_d     = p_q;
    case (state_q)
      IDLE: begin
        if (start) begin
          mreg_d  = {x, 1'b0};
          yreg_d  = y;
          acc_d   = '0;
          cnt_d   = '0;
          state_d = CALC;
        end
      end
      CALC: begin
        acc_d  = acc_sum;
        mreg_d = {{2{mreg_q[WIDTH]}}, mreg_q[WIDTH:2]};
        cnt_d  = cnt_q + 1'b1;
        if (cnt_q == LAST) begin
          p_d     = acc_sum;
          state_d = DONE;
        end
      end
      DONE:    state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= IDLE;
      mreg_q  <= '0;
      yreg_q  <= '0;
      acc_q   <= '0;
      cnt_q   <= '0;
      p_q     <= '0;
    end else begin
      state_q <= state_d;
      mreg_q  <= mreg_d;
      yreg_q  <= yreg_d;
      acc_q   <= acc_d;
      cnt_q   <= cnt_d;
      p_q     <= p_d;
    end
  end

  assign busy = (state_q != IDLE);
  assign done = (state_q == DONE);
  assign p    = p_q;

endmodule

// File: tb/tb_booth_mul_seq.sv
// tb/tb_booth_mul_seq.sv - directed and random checks of booth_mul_seq against signed multiplication
module tb_booth_mul_seq;

  logic        clk = 1'b0;
  logic        rst_n;
  logic        start;
  logic [15:0] x, y;
  logic        busy, done;
  logic [31:0] p;

  int pass_cnt = 0;
  int total_cnt = 0;
  logic [31:0] last_exp;
  int done_cnt, done_at;
  logic [31:0] p_seen;

  booth_mul_seq #(.WIDTH(16)) dut (
    .clk(clk), .rst_n(rst_n), .start(start), .x(x), .y(y),
    .busy(busy), .done(done), .p(p)
  );

  always #5 clk = ~clk;

  function automatic logic [31:0] ref_mul(input logic [15:0] a, input logic [15:0] b);
    logic signed [31:0] sa, sb;
    sa = 32'(signed'(a));
    sb = 32'(signed'(b));
    return 32'(sa * sb);
  endfunction

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    total_cnt++;
    assert (obs === exp) begin
      pass_cnt++;
    end else begin
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  // Start at edge 0; CALC observed after edges 0..7, DONE after edge 8, IDLE after edge 9.
  task automatic run_mul(input logic [15:0] a, input logic [15:0] b, input logic [31:0] exp,
                         input string tag);
    @(negedge clk);
    x = a; y = b; start = 1'b1;
    @(posedge clk);
    @(negedge clk);
    start = 1'b0;
    x = 16'($urandom); y = 16'($urandom);
    for (int k = 0; k < 8; k++) begin
      chk({tag, "_busy_calc"}, busy, 1);
      chk({tag, "_done_calc"}, done, 0);
      chk({tag, "_p_hold"}, p, last_exp);
      @(negedge clk);
    end
    chk({tag, "_done"}, done, 1);
    chk({tag, "_busy_done"}, busy, 1);
    chk({tag, "_p"}, p, exp);
    @(negedge clk);
    chk({tag, "_done_end"}, done, 0);
    chk({tag, "_busy_end"}, busy, 0);
    chk({tag, "_p_keep"}, p, exp);
    last_exp = exp;
  endtask

  initial begin
    rst_n = 1'b0; start = 1'b0; x = '0; y = '0;
    last_exp = '0;
    #1;
    chk("rst_busy", busy, 0);
    chk("rst_done", done, 0);
    chk("rst_p", p, 0);
    @(negedge clk);
    rst_n = 1'b1;

    run_mul(16'h0003, 16'h4d6f, 32'h0000E84D, "small_pos");
    run_mul(16'hFFFF, 16'h4d6f, 32'hFFFFB291, "neg_mul");
    run_mul(16'h8000, 16'h8000, 32'h40000000, "min_min");
    run_mul(16'h7FFF, 16'h8000, 32'hC0008000, "max_min");
    run_mul(16'h0000, 16'h8000, 32'h00000000, "zero_x");
    run_mul(16'h1234, 16'h0000, 32'h00000000, "zero_y");

    @(negedge clk);
    #1 rst_n = 1'b0;
    #1;
    chk("async_busy", busy, 0);
    chk("async_done", done, 0);
    chk("async_p", p, 0);
    #1 rst_n = 1'b1;
    last_exp = '0;

    // Second start during CALC must be ignored.
    @(negedge clk);
    x = 16'h0003; y = 16'h4d6f; start = 1'b1;
    @(posedge clk);
    @(negedge clk);
    start = 1'b0;
    done_cnt = 0; done_at = -1; p_seen = '0;
    for (int k = 0; k < 20; k++) begin
      if (k == 3) begin
        x = 16'h0005; y = 16'h0007; start = 1'b1;
      end
      if (k == 4) start = 1'b0;
      if (done) begin
        done_cnt++;
        done_at = k;
        p_seen = p;
      end
      @(negedge clk);
    end
    chk("guard_done_cnt", done_cnt, 1);
    chk("guard_done_at", done_at, 8);
    chk("guard_p", p_seen, 32'h0000E84D);
    chk("guard_p_after", p, 32'h0000E84D);
    last_exp = 32'h0000E84D;

    // Abort mid-CALC.
    @(negedge clk);
    x = 16'h0003; y = 16'h4d6f; start = 1'b1;
    @(posedge clk);
    @(negedge clk);
    start = 1'b0;
    repeat (3) @(negedge clk);
    #1 rst_n = 1'b0;
    #1;
    chk("abort_busy", busy, 0);
    chk("abort_p", p, 0);
    chk("abort_done", done, 0);
    done_cnt = 0;
    for (int k = 0; k < 12; k++) begin
      @(negedge clk);
      if (done) done_cnt++;
    end
    chk("abort_no_done", done_cnt, 0);
    rst_n = 1'b1;
    last_exp = '0;
    run_mul(16'h0002, 16'h4d6f, 32'h00009ADE, "after_abort");

    for (int i = 0; i < 40; i++) begin
      logic [15:0] ra, rb;
      ra = 16'($urandom);
      rb = 16'($urandom);
      if (i % 8 == 0) ra = 16'h8000;
      if (i % 8 == 1) rb = 16'h7FFF;
      run_mul(ra, rb, ref_mul(ra, rb), $sformatf("rnd%0d", i));
    end

    $display("%0d/%0d checks passed", pass_cnt, total_cnt);
    $finish;
  end

endmodule
